// File: rtl/muldiv_if.sv
// Request/response bundle between the EX stage and the mult/div sequencer,
// including the mthi/mtlo write port and the HI/LO read-out.
interface muldiv_if #(parameter int WIDTH = 32);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] rs_val;
    logic [WIDTH-1:0] rt_val;
    logic             abort;
    logic             hi_we;
    logic             lo_we;
    logic [WIDTH-1:0] wdata;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, rs_val, rt_val, abort, hi_we, lo_we, wdata,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, rs_val, rt_val, abort, hi_we, lo_we, wdata,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/muldiv_seq.sv
// Iterative MIPS mult/multu/div/divu unit owning HI/LO, one bit per cycle.
// Define MULDIV_EARLY_TERM_EN to let multiplies finish once the multiplier runs out of ones.
module muldiv_seq #(
    parameter int WIDTH = 32
) (
    input  logic    clk,
    input  logic    rst,
    muldiv_if.slave bus
);
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [1:0]       op_q, op_d;
    logic             neg_a_q, neg_a_d;
    logic             neg_b_q, neg_b_d;
    logic             dz_q, dz_d;
    // acc: product high half / partial remainder; sh: multiplier / dividend-quotient
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic [WIDTH-1:0] opnd_q, opnd_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             done_q, done_d;

    logic             in_signed;
    logic [WIDTH-1:0] abs_a, abs_b;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH-1:0] div_diff;
    logic             no_borrow;
    logic [2*WIDTH-1:0] prod, prod_fix;
    logic [WIDTH-1:0] quo_fix, rem_fix;

    assign in_signed = ~bus.op[0];
    assign abs_a     = (in_signed && bus.rs_val[WIDTH-1]) ? -bus.rs_val : bus.rs_val;
    assign abs_b     = (in_signed && bus.rt_val[WIDTH-1]) ? -bus.rt_val : bus.rt_val;

    assign mul_sum   = {1'b0, acc_q} + (sh_q[0] ? {1'b0, opnd_q} : '0);
    assign div_shift = {acc_q, sh_q[WIDTH-1]};
    // The true difference always fits in WIDTH bits when there is no borrow
    assign no_borrow = div_shift >= {1'b0, opnd_q};
    assign div_diff  = div_shift[WIDTH-1:0] - opnd_q;

    assign prod      = {acc_q, sh_q};
    assign prod_fix  = (neg_a_q ^ neg_b_q) ? -prod : prod;
    assign quo_fix   = (neg_a_q ^ neg_b_q) ? -sh_q : sh_q;
    assign rem_fix   = neg_a_q ? -acc_q : acc_q;

`ifdef MULDIV_EARLY_TERM_EN
    logic [WIDTH-1:0] live_mask;
    logic [CW-1:0]    left_cnt;
    assign live_mask = {WIDTH{1'b1}} >> cnt_q;
    assign left_cnt  = CW'(WIDTH) - cnt_q;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        neg_a_d = neg_a_q;
        neg_b_d = neg_b_q;
        dz_d    = dz_q;
        acc_d   = acc_q;
        sh_d    = sh_q;
        opnd_d  = opnd_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.hi_we) hi_d = bus.wdata;
                if (bus.lo_we) lo_d = bus.wdata;
                if (bus.start && !bus.abort) begin
                    op_d    = bus.op;
                    neg_a_d = in_signed & bus.rs_val[WIDTH-1];
                    neg_b_d = in_signed & bus.rt_val[WIDTH-1];
                    dz_d    = (bus.rt_val == '0);
                    acc_d   = '0;
                    cnt_d   = '0;
                    sh_d    = bus.op[1] ? abs_a : abs_b;
                    opnd_d  = bus.op[1] ? abs_b : abs_a;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (bus.abort) begin
                    state_d = S_IDLE;
                end else begin
                    if (!op_q[1]) begin
                        acc_d = mul_sum[WIDTH:1];
                        sh_d  = {mul_sum[0], sh_q[WIDTH-1:1]};
                    end else begin
                        acc_d = no_borrow ? div_diff : div_shift[WIDTH-1:0];
                        sh_d  = {sh_q[WIDTH-2:0], no_borrow};
                    end
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CW'(WIDTH - 1)) state_d = S_FIX;
`ifdef MULDIV_EARLY_TERM_EN
                    if (!op_q[1] && ((sh_q & live_mask) == '0)) begin
                        {acc_d, sh_d} = prod >> left_cnt;
                        state_d       = S_FIX;
                    end
`endif
                end
            end
            S_FIX: begin
                state_d = S_IDLE;
                if (!bus.abort) begin
                    done_d = 1'b1;
                    if (op_q[1]) begin
                        hi_d = rem_fix;
                        lo_d = dz_q ? '1 : quo_fix;
                    end else begin
                        hi_d = prod_fix[2*WIDTH-1:WIDTH];
                        lo_d = prod_fix[WIDTH-1:0];
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            neg_a_q <= 1'b0;
            neg_b_q <= 1'b0;
            dz_q    <= 1'b0;
            acc_q   <= '0;
            sh_q    <= '0;
            opnd_q  <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            neg_a_q <= neg_a_d;
            neg_b_q <= neg_b_d;
            dz_q    <= dz_d;
            acc_q   <= acc_d;
            sh_q    <= sh_d;
            opnd_q  <= opnd_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
        end
    end

    assign bus.busy = (state_q != S_IDLE);
    assign bus.done = done_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
endmodule

// File: doc/muldiv_seq.md
Name: muldiv_seq

Overview:
Multi-cycle sequencer for MIPS mult/multu/div/divu, with HI/LO ownership, beside the single-cycle ALU in the EX stage. Accepts one operation per start pulse and iterates a 32-step shift-add (multiply) or restoring shift-subtract (divide). Holds busy so the hazard unit can stall mfhi/mflo and further muldiv ops. Also services mthi/mtlo writes.

Parameters:
WIDTH, 32, operand/HI/LO width; counter width is clog2(WIDTH)+1

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  launch operation; sampled only in IDLE
op  input  2  00 mult, 01 multu, 10 div, 11 divu
rs_val  input  WIDTH  multiplicand / dividend
rt_val  input  WIDTH  multiplier / divisor
abort  input  1  synchronous flush (branch/exception squash)
hi_we  input  1  mthi write enable
lo_we  input  1  mtlo write enable
wdata  input  WIDTH  mthi/mtlo data
busy  output  1  high in RUN and FIX
done  output  1  one-cycle pulse, HI/LO just updated
hi  output  WIDTH  HI register
lo  output  WIDTH  LO register

Behaviour:
- Reset (async, rst=1): state=IDLE, cnt=0, hi=0, lo=0, busy=0, done=0, all internal regs 0. Reset mid-operation discards the operation with no done pulse.
- States: IDLE, RUN, FIX.
- IDLE: if start=1 at edge E0: latch op, record operand signs, and load absolute values (signed ops) or raw values (unsigned ops). Set cnt=0 and go to RUN. start while busy is ignored, not queued.
- RUN: one iteration per edge, E1..E32. Multiply: {acc,mplr} shift-add, 33-bit add. Divide: restoring, 33-bit trial subtract, quotient bit = no-borrow. At cnt=WIDTH-1, go to FIX.
- FIX (edge E33): apply sign correction and write hi/lo, then return to IDLE. done=1 for the cycle after E33; busy=0 in that same cycle. Fixed latency: done visible 33 cycles after the start edge.
- Signed multiply: negate the 64-bit product when the operand signs differ.
- Signed divide: quotient negated when the signs differ; remainder takes the sign of the dividend. 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0 (wrap).
- Divide by zero (div or divu): result forced to hi=rs_val, lo=0xFFFFFFFF. Full latency still taken.
- Results: multiply writes hi=product[63:32], lo=product[31:0]. Divide writes lo=quotient, hi=remainder.
- hi_we/lo_we: take effect only in IDLE and are ignored while busy. When coincident with start in IDLE, both take effect; the muldiv result later overwrites.
- abort: in RUN/FIX, return to IDLE next edge. hi/lo unchanged, no done, busy drops next cycle. abort in IDLE: no effect. abort and start in the same IDLE cycle: abort wins and start is ignored.
- hi/lo are stable and readable at all times outside the FIX write edge.

Optional Feature:
MULDIV_EARLY_TERM_EN
- Defined: for mult/multu in RUN, when the remaining unshifted multiplier bits are all zero, jump to FIX, with the accumulator aligned by a single shift of the remaining count. Latency becomes variable: minimum 2 cycles to done when rt_val=0. Divide is unaffected.
- Undefined: fixed 33-cycle latency for all ops.

Test Plan:
- multu 0xFFFFFFFF*0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; done exactly 33 cycles after the start edge; busy high for 33 cycles.
- mult 0xFFFFFFFD(-3)*7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- div 0xFFFFFFF9(-7)/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. divu 100/7 -> lo=14, hi=2.
- divu 100/0 -> hi=0x00000064, lo=0xFFFFFFFF after full latency. div 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- Pulse start during busy at cycle 5 -> ignored, single done. Assert abort at cycle 10 -> no done, hi/lo keep prior values. Assert rst mid-RUN -> hi=lo=0 immediately.
- mthi 0x1234 in IDLE -> hi=0x1234 next cycle. mtlo while busy -> lo unaffected until the op result lands.
